// File: rtl/calc_core_param_pkg.sv
// rtl/calc_core_param_pkg.sv - shared types for calc_core_param (opcodes, FSM states)
package calc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MUL  = 3'd5,
    OP_DIV  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/calc_core_param_if.sv
// rtl/calc_core_param_if.sv - request/result bundle between register bank and core (CALC_ACCUM_EN adds accum_i)
interface calc_core_param_if #(
  parameter int WIDTH = 8
);
  import calc_pkg::*;

  logic               start_i;
  logic [OP_W-1:0]    op_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
`ifdef CALC_ACCUM_EN
  logic               accum_i;
`endif
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] result_o;
  logic               zero_o;
  logic               carry_o;
  logic               err_o;

  // register bank side
  modport master (
`ifdef CALC_ACCUM_EN
    output accum_i,
`endif
    output start_i, op_i, a_i, b_i,
    input  busy_o, done_o, result_o, zero_o, carry_o, err_o
  );

  // core side
  modport slave (
`ifdef CALC_ACCUM_EN
    input  accum_i,
`endif
    input  start_i, op_i, a_i, b_i,
    output busy_o, done_o, result_o, zero_o, carry_o, err_o
  );

endinterface

// File: rtl/calc_core_param_seq_muldiv.sv
// rtl/calc_core_param_seq_muldiv.sv - shared iterative shift-add multiplier / restoring divider
module calc_seq_muldiv #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] next_res
);

  // hi/lo hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] hi_n, lo_n;

  // one iteration: add-and-shift-right for MUL, shift-left-and-trial-subtract for DIV
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    hi_n     = hi_q;
    lo_n     = lo_q;
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        hi_n = div_diff[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_sh[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign next_res = {hi_n, lo_n};
  assign last     = (cnt_q == '0);

  // operand load and per-cycle step; counter saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= is_div;
      cnt_q <= CNT_W'(WIDTH-1);
    end else if (step) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/calc_core_param.sv
// rtl/calc_core_param.sv - WIDTH-bit calculator core with start/busy/done handshake (CALC_ACCUM_EN: chained operand A)
module calc_core_param
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input logic              clk,
  input logic              rst,
  calc_core_param_if.slave bus
);

  state_e             state;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q, a_sel;
  logic               accept, iterative, md_last;
  logic [2*WIDTH-1:0] md_res, res_next;
  logic               carry_next, err_next;
  logic [WIDTH:0]     sum;

`ifdef CALC_ACCUM_EN
  assign a_sel = bus.accum_i ? bus.result_o[WIDTH-1:0] : bus.a_i;
`else
  assign a_sel = bus.a_i;
`endif

  assign accept    = (state != S_CALC) && bus.start_i;
  assign iterative = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));

  calc_seq_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     ((state == S_CALC) && iterative),
    .is_div   (op_e'(bus.op_i) == OP_DIV),
    .a        (a_sel),
    .b        (bus.b_i),
    .last     (md_last),
    .next_res (md_res)
  );

  // result and flags that will be captured on the edge entering DONE
  always_comb begin
    sum        = {1'b0, a_q} + {1'b0, b_q};
    res_next   = '0;
    carry_next = 1'b0;
    err_next   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_next   = {{(WIDTH-1){1'b0}}, sum};
        carry_next = sum[WIDTH];
      end
      OP_SUB: begin
        res_next   = {{WIDTH{1'b0}}, a_q - b_q};
        carry_next = (a_q < b_q);
      end
      OP_AND: res_next = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:  res_next = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR: res_next = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_MUL: res_next = md_res;
      OP_DIV: begin
        if (b_q == '0) begin
          res_next = {a_q, {WIDTH{1'b1}}};
          err_next = 1'b1;
        end else begin
          res_next = md_res;
        end
      end
      default: err_next = 1'b1;
    endcase
  end

  // control FSM with registered handshake, result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      bus.busy_o   <= 1'b0;
      bus.done_o   <= 1'b0;
      bus.result_o <= '0;
      bus.zero_o   <= 1'b1;
      bus.carry_o  <= 1'b0;
      bus.err_o    <= 1'b0;
    end else begin
      case (state)
        S_CALC: begin
          if (!iterative || md_last) begin
            state        <= S_DONE;
            bus.busy_o   <= 1'b0;
            bus.done_o   <= 1'b1;
            bus.result_o <= res_next;
            bus.zero_o   <= (res_next == '0);
            bus.carry_o  <= carry_next;
            bus.err_o    <= err_next;
          end
        end
        default: begin
          bus.done_o <= 1'b0;
          if (accept) begin
            state      <= S_CALC;
            op_q       <= op_e'(bus.op_i);
            a_q        <= a_sel;
            b_q        <= bus.b_i;
            bus.busy_o <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_core_param.sv
// tb/tb_calc_core_param.sv - directed self-checking bench for calc_core_param (WIDTH=8, CALC_ACCUM_EN optional)
module tb_calc_core_param;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  calc_core_param_if #(.WIDTH(8)) bus();

  calc_core_param #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // apply an op for one edge; returns at the negedge after the accepting edge
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // count negedges until done_o, bounded
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done_o && cyc < 50);
  endtask

  task automatic test_reset();
    total++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy_o); else pass_cnt++;
    total++; if (bus.done_o !== 1'b0) $display("FAIL rst_done got %b exp 0", bus.done_o); else pass_cnt++;
    total++; if (bus.result_o !== 16'h0000) $display("FAIL rst_result got %h exp 0000", bus.result_o); else pass_cnt++;
    total++; if ({bus.zero_o, bus.carry_o, bus.err_o} !== 3'b100) $display("FAIL rst_flags got %b exp 100", {bus.zero_o, bus.carry_o, bus.err_o}); else pass_cnt++;
  endtask

  task automatic test_single_cycle();
    int cyc;
    issue(OP_ADD, 8'd200, 8'd100); wait_done(cyc);
    total++; if (cyc !== 1) $display("FAIL add_latency got %0d exp 1", cyc); else pass_cnt++;
    total++; if (bus.result_o !== 16'h012C) $display("FAIL add_result got %h exp 012c", bus.result_o); else pass_cnt++;
    total++; if ({bus.zero_o, bus.carry_o, bus.err_o} !== 3'b010) $display("FAIL add_flags got %b exp 010", {bus.zero_o, bus.carry_o, bus.err_o}); else pass_cnt++;
    @(negedge clk);
    total++; if (bus.done_o !== 1'b0) $display("FAIL add_done_pulse got %b exp 0", bus.done_o); else pass_cnt++;
    issue(OP_SUB, 8'd5, 8'd7); wait_done(cyc);
    total++; if (bus.result_o !== 16'h00FE) $display("FAIL sub_result got %h exp 00fe", bus.result_o); else pass_cnt++;
    total++; if (bus.carry_o !== 1'b1) $display("FAIL sub_borrow got %b exp 1", bus.carry_o); else pass_cnt++;
    issue(OP_AND, 8'hF0, 8'h3C); wait_done(cyc);
    total++; if ({bus.result_o, bus.carry_o} !== {16'h0030, 1'b0}) $display("FAIL and_result got %h/%b exp 0030/0", bus.result_o, bus.carry_o); else pass_cnt++;
    issue(OP_OR, 8'hF0, 8'h0F); wait_done(cyc);
    total++; if (bus.result_o !== 16'h00FF) $display("FAIL or_result got %h exp 00ff", bus.result_o); else pass_cnt++;
    issue(OP_RSVD, 8'h12, 8'h34); wait_done(cyc);
    total++; if ({cyc[3:0], bus.result_o, bus.err_o, bus.zero_o} !== {4'd1, 16'h0000, 1'b1, 1'b1}) $display("FAIL rsvd got cyc=%0d res=%h err=%b zero=%b exp 1/0000/1/1", cyc, bus.result_o, bus.err_o, bus.zero_o); else pass_cnt++;
  endtask

  task automatic test_mul();
    int busy_cnt;
    int iter;
    issue(OP_MUL, 8'd255, 8'd255);
    busy_cnt = bus.busy_o ? 1 : 0;
    iter = 0;
    while (!bus.done_o && iter < 50) begin
      @(negedge clk);
      iter++;
      if (iter == 3) begin bus.start_i = 1'b1; bus.op_i = OP_ADD; bus.a_i = 8'd1; bus.b_i = 8'd1; end
      if (iter == 4) bus.start_i = 1'b0;
      if (bus.busy_o) busy_cnt++;
    end
    total++; if (busy_cnt !== 8) $display("FAIL mul_busy_cycles got %0d exp 8", busy_cnt); else pass_cnt++;
    total++; if (iter !== 8) $display("FAIL mul_latency got %0d exp 8", iter); else pass_cnt++;
    total++; if (bus.result_o !== 16'hFE01) $display("FAIL mul_result got %h exp fe01", bus.result_o); else pass_cnt++;
    total++; if ({bus.zero_o, bus.carry_o, bus.err_o} !== 3'b000) $display("FAIL mul_flags got %b exp 000", {bus.zero_o, bus.carry_o, bus.err_o}); else pass_cnt++;
    @(negedge clk);
    total++; if ({bus.done_o, bus.busy_o} !== 2'b00) $display("FAIL mul_after got done/busy %b exp 00", {bus.done_o, bus.busy_o}); else pass_cnt++;
  endtask

  task automatic test_div();
    int cyc;
    issue(OP_DIV, 8'd100, 8'd7); wait_done(cyc);
    total++; if (cyc !== 8) $display("FAIL div_latency got %0d exp 8", cyc); else pass_cnt++;
    total++; if ({bus.result_o, bus.err_o} !== {16'h020E, 1'b0}) $display("FAIL div_result got %h/%b exp 020e/0", bus.result_o, bus.err_o); else pass_cnt++;
    issue(OP_DIV, 8'd9, 8'd0); wait_done(cyc);
    total++; if (cyc !== 1) $display("FAIL div0_latency got %0d exp 1", cyc); else pass_cnt++;
    total++; if ({bus.result_o, bus.err_o} !== {16'h09FF, 1'b1}) $display("FAIL div0_result got %h/%b exp 09ff/1", bus.result_o, bus.err_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.op_i = OP_ADD; bus.a_i = 8'd1; bus.b_i = 8'd1; bus.start_i = 1'b1;
    @(negedge clk);
    bus.op_i = OP_XOR; bus.a_i = 8'hF0; bus.b_i = 8'hF0;
    @(negedge clk);
    total++; if ({bus.done_o, bus.result_o} !== {1'b1, 16'h0002}) $display("FAIL b2b_first got %b/%h exp 1/0002", bus.done_o, bus.result_o); else pass_cnt++;
    @(negedge clk);
    total++; if ({bus.busy_o, bus.done_o} !== 2'b10) $display("FAIL b2b_accept got busy/done %b exp 10", {bus.busy_o, bus.done_o}); else pass_cnt++;
    bus.start_i = 1'b0;
    @(negedge clk);
    total++; if ({bus.done_o, bus.result_o, bus.zero_o} !== {1'b1, 16'h0000, 1'b1}) $display("FAIL b2b_second got %b/%h/%b exp 1/0000/1", bus.done_o, bus.result_o, bus.zero_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_calc();
    int cyc;
    int done_seen;
    issue(OP_ADD, 8'd200, 8'd100); wait_done(cyc);
    issue(OP_MUL, 8'd255, 8'd255);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({bus.busy_o, bus.done_o, bus.result_o, bus.zero_o, bus.carry_o, bus.err_o} !== {2'b00, 16'h0000, 3'b100})
      $display("FAIL abort_outputs got busy=%b done=%b res=%h zero=%b carry=%b err=%b exp 0/0/0000/1/0/0", bus.busy_o, bus.done_o, bus.result_o, bus.zero_o, bus.carry_o, bus.err_o); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) done_seen++;
    end
    total++; if (done_seen !== 0) $display("FAIL abort_no_done got %0d exp 0", done_seen); else pass_cnt++;
    issue(OP_ADD, 8'd3, 8'd4); wait_done(cyc);
    total++; if ({cyc[3:0], bus.result_o, bus.carry_o} !== {4'd1, 16'h0007, 1'b0}) $display("FAIL post_abort_add got %0d/%h/%b exp 1/0007/0", cyc, bus.result_o, bus.carry_o); else pass_cnt++;
  endtask

`ifdef CALC_ACCUM_EN
  task automatic test_accum();
    int cyc;
    issue(OP_ADD, 8'd3, 8'd4); wait_done(cyc);
    bus.accum_i = 1'b1;
    issue(OP_MUL, 8'd0, 8'd6);
    bus.accum_i = 1'b0;
    wait_done(cyc);
    total++; if (bus.result_o !== 16'd42) $display("FAIL accum_mul got %h exp 002a", bus.result_o); else pass_cnt++;
  endtask
`endif

  initial begin
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
`ifdef CALC_ACCUM_EN
    bus.accum_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_single_cycle();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_calc();
`ifdef CALC_ACCUM_EN
    test_accum();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
